avalon_sdr_responder: RTL and testbench

AVALON_SDR_RESPONDER -- requirements
Module: avalon_sdr_responder

---
 rtl/avalon_sdr_responder.sv | 126 ++++++++++++
 tb/tb_avalon_sdr_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_sdr_responder.sv
// Avalon-MM 16-bit memory responder: fixed waitrequest stall per command,
// pipelined read return with bounded outstanding reads, sticky error flags.
module avalon_sdr_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_WORDS   = 256,
  parameter int          WAIT_CYCLES  = 1,
  parameter int          READ_LATENCY = 2,
  parameter int          MAX_PENDING  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_address,
  input  logic [15:0] avs_s0_writedata,
  input  logic [1:0]  avs_s0_byteenable,
  output logic [15:0] avs_s0_readdata,
  output logic        avs_s0_readdatavalid,
  output logic        avs_s0_waitrequest,
  output logic [2:0]  err_flags,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);
  localparam int AW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] MAXP  = PW'(MAX_PENDING);
  localparam logic [3:0]    WC_M1 = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t  r_state;
  logic [3:0]    r_cnt;
  logic [PW-1:0] r_pend;
  logic [15:0]   r_mem [ADDR_WORDS];
  logic [READ_LATENCY-1:0]       r_vld_pipe;
  logic [READ_LATENCY-1:0][15:0] r_dat_pipe;

  logic        w_cmd, w_rd_only, w_at_pt, w_blocked, w_acc, w_wr_acc, w_rd_acc, w_rdv, w_range;
  logic [31:0] w_off, w_idx;
  logic [15:0] w_rd_word;

  assign w_cmd     = avs_s0_read | avs_s0_write;
  assign w_rd_only = avs_s0_read & ~avs_s0_write;
  assign w_off     = avs_s0_address - BASE_ADDR;
  assign w_idx     = {1'b0, w_off[31:1]};
  assign w_range   = (w_idx >= 32'(ADDR_WORDS));

  // Accept point: IDLE when there is no stall, otherwise the last WAIT cycle.
  assign w_at_pt   = w_cmd && (((r_state == S_IDLE) && (WAIT_CYCLES == 0)) ||
                               ((r_state == S_WAIT) && (r_cnt == 4'd0)));
  assign w_blocked = w_rd_only && (r_pend == MAXP);
  assign w_acc     = ~reset & w_at_pt & ~w_blocked;
  assign w_wr_acc  = w_acc & avs_s0_write;
  assign w_rd_acc  = w_acc & w_rd_only;

  assign avs_s0_waitrequest   = ~w_acc;
  assign w_rdv                = r_vld_pipe[READ_LATENCY-1];
  assign avs_s0_readdatavalid = w_rdv;
  assign avs_s0_readdata      = w_rdv ? r_dat_pipe[READ_LATENCY-1] : 16'h0000;

  always_comb begin
    w_rd_word = 16'hDEAD;
    if (!w_range) w_rd_word = r_mem[w_idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_cmd && (WAIT_CYCLES != 0)) begin
          r_state <= S_WAIT;
          r_cnt   <= WC_M1;
        end
        S_WAIT: begin
          if (!w_cmd)              r_state <= S_IDLE;
          else if (r_cnt != 4'd0)  r_cnt   <= r_cnt - 4'd1;
          else if (w_acc)          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= '0;
      err_flags <= 3'b000;
      wr_count  <= 16'h0000;
      rd_count  <= 16'h0000;
    end else begin
      case ({w_rd_acc, w_rdv})
        2'b10:   r_pend <= r_pend + PW'(1);
        2'b01:   r_pend <= r_pend - PW'(1);
        default: r_pend <= r_pend;
      endcase
      if (w_acc && avs_s0_address[0])            err_flags[1] <= 1'b1;
      if (w_acc && w_range)                      err_flags[0] <= 1'b1;
      if (w_wr_acc && avs_s0_read)               err_flags[2] <= 1'b1;
      if (w_wr_acc)                              wr_count <= wr_count + 16'd1;
      if (w_rd_acc)                              rd_count <= rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[0] <= w_rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_dat_pipe[0] <= w_rd_word;
    for (int i = 1; i < READ_LATENCY; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_range) begin
      if (avs_s0_byteenable[0]) r_mem[w_idx[AW-1:0]][7:0]  <= avs_s0_writedata[7:0];
      if (avs_s0_byteenable[1]) r_mem[w_idx[AW-1:0]][15:8] <= avs_s0_writedata[15:8];
    end
  end
endmodule

// File: tb/tb_avalon_sdr_responder.sv
// Scoreboard bench: instance 0 uses defaults, instance 1 uses WAIT=0, LAT=4, MAX_PENDING=2.
module tb_avalon_sdr_responder;
  typedef struct { logic [15:0] d; int cyc; } sb_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        rd [2], wr [2];
  logic [31:0] ad [2];
  logic [15:0] wd [2];
  logic [1:0]  be [2];
  logic [15:0] rdat [2], wcnt [2], rcnt [2];
  logic        rdv [2], wrq [2];
  logic [2:0]  err [2];

  logic [15:0] mm [2][256];
  logic [2:0]  m_err [2];
  logic [15:0] m_wc [2], m_rc [2];
  sb_t q0[$], q1[$];
  int LAT [2] = '{2, 4};
  int cyc = 0, n_chk = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_sdr_responder u_a (
    .clk(clk), .reset(rst[0]), .avs_s0_read(rd[0]), .avs_s0_write(wr[0]),
    .avs_s0_address(ad[0]), .avs_s0_writedata(wd[0]), .avs_s0_byteenable(be[0]),
    .avs_s0_readdata(rdat[0]), .avs_s0_readdatavalid(rdv[0]), .avs_s0_waitrequest(wrq[0]),
    .err_flags(err[0]), .wr_count(wcnt[0]), .rd_count(rcnt[0]));

  avalon_sdr_responder #(.WAIT_CYCLES(0), .READ_LATENCY(4), .MAX_PENDING(2)) u_b (
    .clk(clk), .reset(rst[1]), .avs_s0_read(rd[1]), .avs_s0_write(wr[1]),
    .avs_s0_address(ad[1]), .avs_s0_writedata(wd[1]), .avs_s0_byteenable(be[1]),
    .avs_s0_readdata(rdat[1]), .avs_s0_readdatavalid(rdv[1]), .avs_s0_waitrequest(wrq[1]),
    .err_flags(err[1]), .wr_count(wcnt[1]), .rd_count(rcnt[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Read-return monitor: pops the scoreboard on every valid pulse.
  always @(negedge clk) begin
    sb_t e;
    for (int s = 0; s < 2; s++) begin
      if (rdv[s]) begin
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0))
          chk($sformatf("spurious_rdv%0d", s), 1, 0);
        else begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rdata%0d", s), {16'h0, rdat[s]}, {16'h0, e.d});
          chk($sformatf("rdv_cyc%0d", s), cyc, e.cyc);
        end
      end else
        chk($sformatf("rdata_idle%0d", s), {16'h0, rdat[s]}, 32'h0);
    end
  end

  task automatic drive_idle(input int s);
    rd[s] = 0; wr[s] = 0; ad[s] = '0; wd[s] = '0; be[s] = '0;
  endtask

  task automatic chk_regs(input int s);
    chk($sformatf("err%0d", s),  {29'h0, err[s]},  {29'h0, m_err[s]});
    chk($sformatf("wcnt%0d", s), {16'h0, wcnt[s]}, {16'h0, m_wc[s]});
    chk($sformatf("rcnt%0d", s), {16'h0, rcnt[s]}, {16'h0, m_rc[s]});
  endtask

  // Caller is at a negedge; returns at the negedge after acceptance.
  task automatic bus(input int s, input bit r, input bit w, input logic [31:0] a,
                     input logic [15:0] d, input logic [1:0] b, input int exp_wait);
    int n = 0;
    logic [31:0] idx;
    sb_t e;
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d; be[s] = b;
    #1;
    while (wrq[s] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    else begin
      chk($sformatf("wait%0d", s), n, exp_wait);
      idx = a >> 1;
      if (a[0]) m_err[s][1] = 1'b1;
      if (idx >= 256) m_err[s][0] = 1'b1;
      if (w) begin
        if (r) m_err[s][2] = 1'b1;
        if (idx < 256) begin
          if (b[0]) mm[s][idx][7:0]  = d[7:0];
          if (b[1]) mm[s][idx][15:8] = d[15:8];
        end
        m_wc[s]++;
      end else begin
        e.d = (idx >= 256) ? 16'hDEAD : mm[s][idx];
        e.cyc = cyc + LAT[s];
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        m_rc[s]++;
      end
    end
    @(negedge clk);
    drive_idle(s);
  endtask

  task automatic do_reset(input int s);
    rst[s] = 1'b1; drive_idle(s);
    if (s == 0) q0.delete(); else q1.delete();
    m_err[s] = '0; m_wc[s] = '0; m_rc[s] = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_wrq", wrq[s], 1);
    chk("rst_rdv", rdv[s], 0);
    chk("rst_rdat", rdat[s], 0);
    chk_regs(s);
    rst[s] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin rst[s] = 1'b1; drive_idle(s); end
    @(negedge clk);
    fork do_reset(0); do_reset(1); join

    // Basic write then read, byte enables, idle waitrequest
    bus(0, 0, 1, 32'h10, 16'h1234, 2'b11, 1);
    chk_regs(0);
    #1 chk("idle_wrq", wrq[0], 1);
    @(negedge clk); @(negedge clk);
    bus(0, 1, 0, 32'h10, 16'h0, 2'b00, 1);
    bus(0, 0, 1, 32'h10, 16'hFFEE, 2'b01, 1);
    bus(0, 1, 0, 32'h10, 16'h0, 2'b00, 1);
    bus(0, 0, 1, 32'h10, 16'h0000, 2'b00, 1);
    bus(0, 1, 0, 32'h10, 16'h0, 2'b00, 1);
    repeat (3) @(negedge clk);
    chk_regs(0);

    // Range, proto, unaligned
    bus(0, 1, 0, 32'h200, 16'h0, 2'b00, 1);
    repeat (3) @(negedge clk);
    chk_regs(0);
    bus(0, 1, 1, 32'h12, 16'h5555, 2'b11, 1);
    bus(0, 1, 0, 32'h12, 16'h0, 2'b00, 1);
    bus(0, 0, 1, 32'h11, 16'hAAAA, 2'b11, 1);
    bus(0, 1, 0, 32'h10, 16'h0, 2'b00, 1);
    bus(0, 0, 1, 32'hFFFF_FFF0, 16'h7777, 2'b11, 1);
    repeat (3) @(negedge clk);
    chk_regs(0);

    // Master drops the command mid-stall
    wr[0] = 1; ad[0] = 32'h20; wd[0] = 16'hBEEF; be[0] = 2'b11;
    #1 chk("drop_wrq0", wrq[0], 1);
    @(negedge clk); drive_idle(0);
    #1 chk("drop_wrq1", wrq[0], 1);
    @(negedge clk); @(negedge clk);
    chk_regs(0);
    bus(0, 0, 1, 32'h20, 16'hBEEF, 2'b11, 1);
    bus(0, 1, 0, 32'h20, 16'h0, 2'b00, 1);
    repeat (3) @(negedge clk);

    // Reset with a read in flight, then storage survives
    bus(0, 1, 0, 32'h12, 16'h0, 2'b00, 1);
    do_reset(0);
    repeat (4) @(negedge clk);
    bus(0, 1, 0, 32'h12, 16'h0, 2'b00, 1);
    bus(0, 1, 0, 32'h20, 16'h0, 2'b00, 1);
    repeat (3) @(negedge clk);
    chk_regs(0);

    // Zero-wait instance: pending limit stalls the third read
    bus(1, 0, 1, 32'h0, 16'h0101, 2'b11, 0);
    bus(1, 0, 1, 32'h2, 16'h0202, 2'b11, 0);
    bus(1, 0, 1, 32'h4, 16'h0303, 2'b11, 0);
    repeat (2) @(negedge clk);
    bus(1, 1, 0, 32'h0, 16'h0, 2'b00, 0);
    bus(1, 1, 0, 32'h2, 16'h0, 2'b00, 0);
    bus(1, 1, 0, 32'h4, 16'h0, 2'b00, 3);
    repeat (8) @(negedge clk);
    chk_regs(1);

    repeat (6) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
